// File: rtl/icache_bus_responder_pkg.sv
// Shared types for the icache refill bus responder: burst request/response
// records, the sequencer state encoding and the bus word size.
package icache_bus_responder_pkg;

    localparam int WORD_BYTES = 4;
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_LEN_W  = 4;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_LEN_W-1:0]  len;
        logic                  wrap;
    } burst_req_t;

    typedef struct packed {
        logic [BUS_DATA_W-1:0] data;
        logic                  last;
    } burst_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } bus_state_e;

endpackage

// File: rtl/icache_bus_responder_skid_fifo2.sv
// Two-entry FIFO used as the response skid buffer; head is visible on dout
// whenever empty is low.
module skid_fifo2
    import icache_bus_responder_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [1:0][W-1:0] slot;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot   <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= din;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = slot[rd_ptr];
    assign full  = (cnt == 2'd2);
    assign empty = (cnt == 2'd0);

endmodule

// File: rtl/icache_bus_responder.sv
// Icache refill bus responder: accepts read bursts, issues word reads to a
// synchronous memory port and streams beats back through a 2-entry skid FIFO.
module icache_bus_responder
    import icache_bus_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [LEN_WIDTH-1:0]  req_len_i,
    input  logic                  req_wrap_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_data_o,
    output logic                  resp_last_o,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  bus_busy_o
);

    localparam int WORD_AW = ADDR_WIDTH - WORD_SHIFT;
    localparam int LW1     = LEN_WIDTH + 1;

    // Wrapping bursts of a power-of-two length rotate the low word bits inside
    // the aligned block; every other case is a plain word increment.
    function automatic logic [ADDR_WIDTH-1:0] beat_addr(
        input logic [WORD_AW-1:0]   start,
        input logic [LEN_WIDTH-1:0] len,
        input logic                 wrap,
        input logic [LW1-1:0]       idx
    );
        logic [WORD_AW-1:0] mask;
        logic [WORD_AW-1:0] inc;
        logic [WORD_AW-1:0] word;
        logic [LW1-1:0]     beats;
        mask  = WORD_AW'(len);
        inc   = start + WORD_AW'(idx);
        beats = LW1'(len) + LW1'(1);
        if (wrap && ((beats & LW1'(len)) == '0))
            word = (start & ~mask) | (inc & mask);
        else
            word = inc;
        return {word, {WORD_SHIFT{1'b0}}};
    endfunction

    bus_state_e           state;
    burst_req_t           req_q;
    logic [LW1-1:0]       issue_cnt;
    logic [LEN_WIDTH-1:0] resp_cnt;
    logic                 rd_vld;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic [1:0]            fifo_cnt;
    logic [2:0]            occ_after;
    logic                  can_issue;
    logic                  resp_hs;
    logic [LW1-1:0]        len_plus1;
    burst_resp_t           resp;
    logic                  unused_addr_lsb;

    // Read data bypasses the FIFO when it is empty and the beat is taken at once.
    assign resp_valid_o = !fifo_empty || rd_vld;
    assign resp_hs      = resp_valid_o && resp_ready_i;
    assign fifo_push    = rd_vld && !(fifo_empty && resp_ready_i);
    assign fifo_pop     = !fifo_empty && resp_ready_i;
    assign fifo_cnt     = {fifo_full, !fifo_full && !fifo_empty};

    // Beats owed after this edge: buffered + returning + issued - taken now.
    assign occ_after = 3'(fifo_cnt) + 3'(rd_vld) + 3'(mem_en_o) - 3'(resp_hs);
    assign can_issue = (occ_after <= 3'd1);
    assign len_plus1 = LW1'(req_q.len) + LW1'(1);

    always_comb begin
        resp      = '0;
        resp.data = fifo_empty ? (rd_vld ? mem_rdata_i : '0) : fifo_dout;
        resp.last = resp_valid_o && (resp_cnt == req_q.len);
    end

    assign resp_data_o     = resp.data;
    assign resp_last_o     = resp.last;
    assign unused_addr_lsb = ^req_q.addr[WORD_SHIFT-1:0];

    skid_fifo2 #(.W(DATA_WIDTH)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (mem_rdata_i),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            req_q       <= '0;
            issue_cnt   <= '0;
            resp_cnt    <= '0;
            rd_vld      <= 1'b0;
            mem_en_o    <= 1'b0;
            mem_addr_o  <= '0;
            req_ready_o <= 1'b0;
            bus_busy_o  <= 1'b0;
        end else begin
            rd_vld   <= mem_en_o;
            mem_en_o <= 1'b0;
            if (resp_hs)
                resp_cnt <= resp_cnt + LEN_WIDTH'(1);
            unique case (state)
                ST_IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        req_q       <= '{addr: req_addr_i, len: req_len_i, wrap: req_wrap_i};
                        mem_en_o    <= 1'b1;
                        mem_addr_o  <= beat_addr(req_addr_i[ADDR_WIDTH-1:WORD_SHIFT],
                                                 req_len_i, req_wrap_i, '0);
                        issue_cnt   <= LW1'(1);
                        resp_cnt    <= '0;
                        req_ready_o <= 1'b0;
                        bus_busy_o  <= 1'b1;
                        state       <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (issue_cnt == len_plus1) begin
                        state <= ST_DRAIN;
                    end else if (can_issue) begin
                        mem_en_o   <= 1'b1;
                        mem_addr_o <= beat_addr(req_q.addr[ADDR_WIDTH-1:WORD_SHIFT],
                                                req_q.len, req_q.wrap, issue_cnt);
                        issue_cnt  <= issue_cnt + LW1'(1);
                    end
                end
                ST_DRAIN: begin
                    if (resp_hs && (resp_cnt == req_q.len)) begin
                        state       <= ST_IDLE;
                        req_ready_o <= 1'b1;
                        bus_busy_o  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_bus_responder.sv
// Directed bench for icache_bus_responder: a table of bursts with hand-written
// beat addresses, plus reset checks and a reset-mid-burst sequence.
module tb_icache_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic        req_wrap;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_last;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        bus_busy;

    icache_bus_responder dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_len_i    (req_len),
        .req_wrap_i   (req_wrap),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .resp_last_o  (resp_last),
        .mem_en_o     (mem_en),
        .mem_addr_o   (mem_addr),
        .mem_rdata_i  (mem_rdata),
        .bus_busy_o   (bus_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    // Synchronous-read memory; garbage when not enabled so stale reads show up.
    always @(posedge clk)
        mem_rdata <= mem_en ? memf(mem_addr) : 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0]       addr;
        logic [3:0]        len;
        logic              wrap;
        logic              bp;
        logic [15:0][31:0] exp;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];
    int   total = 0;
    int   bad   = 0;
    int   cur   = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL vec%0d %s: got %h want %h", cur, nm, act, exp);
        end
    endtask

    function automatic vec_t mkvec(input logic [31:0] a, input logic [3:0] l,
                                   input logic w, input logic b);
        vec_t v;
        v      = '0;
        v.addr = a;
        v.len  = l;
        v.wrap = w;
        v.bp   = b;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int issued, recv, cyc, first_cyc, last_cyc;
        logic        stalled;
        logic [31:0] prev;
        @(negedge clk);
        chk("ready_in_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_addr   = v.addr;
        req_len    = v.len;
        req_wrap   = v.wrap;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        issued = 0; recv = 0; cyc = 1; first_cyc = -1; last_cyc = -1;
        stalled = 1'b0; prev = '0;
        while (recv <= int'(v.len) && cyc < 200) begin
            resp_ready = v.bp ? ((cyc % 3) == 2) : 1'b1;
            #1;
            chk("busy", 32'(bus_busy), 32'd1);
            chk("ready_busy", 32'(req_ready), 32'd0);
            if (mem_en) begin
                if (issued <= int'(v.len))
                    chk("mem_addr", mem_addr, v.exp[issued]);
                else
                    chk("extra_issue", 32'(issued), 32'(v.len));
                issued++;
            end
            chk("outstanding_le2", 32'((issued - recv) <= 2), 32'd1);
            if (stalled) begin
                chk("stall_valid", 32'(resp_valid), 32'd1);
                chk("stall_data", resp_data, prev);
            end
            if (resp_valid) begin
                chk("data", resp_data, memf(v.exp[recv]));
                chk("last", 32'(resp_last), 32'(recv == int'(v.len)));
                if (first_cyc < 0) first_cyc = cyc;
                prev    = resp_data;
                stalled = !resp_ready;
                if (resp_ready) begin
                    recv++;
                    last_cyc = cyc;
                end
            end else begin
                stalled = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("all_beats", 32'(recv), 32'(v.len) + 32'd1);
        chk("issue_count", 32'(issued), 32'(v.len) + 32'd1);
        chk("busy_after", 32'(bus_busy), 32'd0);
        chk("ready_after", 32'(req_ready), 32'd1);
        chk("valid_after", 32'(resp_valid), 32'd0);
        if (!v.bp) begin
            chk("first_beat_cycle", 32'(first_cyc), 32'd2);
            chk("last_beat_cycle", 32'(last_cyc), 32'(v.len) + 32'd2);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_last"}, 32'(resp_last), 32'd0);
        chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        chk({tag, "_bus_busy"}, 32'(bus_busy), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_resp_data"}, resp_data, 32'd0);
    endtask

    initial begin
        int   beats;
        logic found;

        vecs[0] = mkvec(32'h1C00_0000, 4'd0, 1'b0, 1'b0);
        vecs[0].exp[0] = 32'h1C00_0000;
        vecs[1] = mkvec(32'h1C00_0008, 4'd3, 1'b1, 1'b0);
        vecs[1].exp[0] = 32'h1C00_0008; vecs[1].exp[1] = 32'h1C00_000C;
        vecs[1].exp[2] = 32'h1C00_0000; vecs[1].exp[3] = 32'h1C00_0004;
        vecs[2] = mkvec(32'h0000_FFF8, 4'd3, 1'b0, 1'b0);
        vecs[2].exp[0] = 32'h0000_FFF8; vecs[2].exp[1] = 32'h0000_FFFC;
        vecs[2].exp[2] = 32'h0001_0000; vecs[2].exp[3] = 32'h0001_0004;
        vecs[3] = mkvec(32'h0000_0100, 4'd7, 1'b0, 1'b1);
        for (int j = 0; j < 8; j++) vecs[3].exp[j] = 32'h100 + 32'(4 * j);
        vecs[4] = mkvec(32'h0000_0004, 4'd2, 1'b1, 1'b0);
        vecs[4].exp[0] = 32'h4; vecs[4].exp[1] = 32'h8; vecs[4].exp[2] = 32'hC;
        vecs[5] = mkvec(32'h0000_0134, 4'd7, 1'b1, 1'b0);
        vecs[5].exp[0] = 32'h134; vecs[5].exp[1] = 32'h138;
        vecs[5].exp[2] = 32'h13C; vecs[5].exp[3] = 32'h120;
        vecs[5].exp[4] = 32'h124; vecs[5].exp[5] = 32'h128;
        vecs[5].exp[6] = 32'h12C; vecs[5].exp[7] = 32'h130;
        vecs[6] = mkvec(32'h0000_0FF0, 4'd15, 1'b1, 1'b1);
        for (int j = 0; j < 4; j++)  vecs[6].exp[j] = 32'hFF0 + 32'(4 * j);
        for (int j = 4; j < 16; j++) vecs[6].exp[j] = 32'hFC0 + 32'(4 * (j - 4));
        vecs[7] = mkvec(32'hFFFF_FFFC, 4'd1, 1'b1, 1'b0);
        vecs[7].exp[0] = 32'hFFFF_FFFC; vecs[7].exp[1] = 32'hFFFF_FFF8;
        vecs[8] = mkvec(32'hFFFF_FFF8, 4'd3, 1'b0, 1'b0);
        vecs[8].exp[0] = 32'hFFFF_FFF8; vecs[8].exp[1] = 32'hFFFF_FFFC;
        vecs[8].exp[2] = 32'h0000_0000; vecs[8].exp[3] = 32'h0000_0004;
        vecs[9] = mkvec(32'h0000_0203, 4'd1, 1'b0, 1'b1);
        vecs[9].exp[0] = 32'h200; vecs[9].exp[1] = 32'h204;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_len    = '0;
        req_wrap   = 1'b0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_release", 32'(req_ready), 32'd1);
        chk("busy_after_release", 32'(bus_busy), 32'd0);

        for (int i = 0; i < NV; i++) begin
            cur = i;
            run_vec(vecs[i]);
        end

        // Reset while the third beat of a 16-beat burst is on the bus.
        cur = 100;
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = 32'h0000_2000;
        req_len    = 4'd15;
        req_wrap   = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        beats = 0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (resp_valid && beats == 2) found = 1'b1;
            else begin
                if (resp_valid) beats++;
                @(negedge clk);
            end
        end
        chk("reach_beat3", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        chk("midrst_ready_back", 32'(req_ready), 32'd1);
        chk("midrst_drop_inflight", 32'(resp_valid), 32'd0);
        chk("midrst_idle", 32'(bus_busy), 32'd0);

        cur = 101;
        vecs[0] = mkvec(32'h0000_0040, 4'd0, 1'b0, 1'b0);
        vecs[0].exp[0] = 32'h0000_0040;
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_bus_responder.md
# icache_bus_responder

Responder end of the instruction-cache refill bus. It accepts read-burst requests from the icache miss path, such as line refills and uncached single fetches. It sequences word reads into a synchronous-read memory port and returns the data beats in order with valid/ready backpressure. It sits between the frontend's cache bus and the memory-side arbiter, and it drives the bus-busy indication that the frontend samples.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: beat width. Fixed at one instruction word.
- `LEN_WIDTH`, 4: burst-length field width. A burst carries `len+1` beats, at most 16.

Ports:
- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `req_valid_i` input 1: the request is valid.
- `req_ready_o` output 1: the block accepts a request.
- `req_addr_i` input ADDR_WIDTH: start byte address. Bits [1:0] are ignored.
- `req_len_i` input LEN_WIDTH: beats minus one.
- `req_wrap_i` input 1: 1 selects a critical-word-first wrapping burst; 0 selects an incrementing burst.
- `resp_valid_o` output 1: a data beat is valid.
- `resp_ready_i` input 1: the initiator accepts the beat.
- `resp_data_o` output DATA_WIDTH: beat data.
- `resp_last_o` output 1: final beat of the burst.
- `mem_en_o` output 1: memory read strobe.
- `mem_addr_o` output ADDR_WIDTH: word-aligned read address.
- `mem_rdata_i` input DATA_WIDTH: read data, valid exactly one cycle after `mem_en_o`.
- `bus_busy_o` output 1: a burst is in progress.

## Operation
- FSM has three states:
  - IDLE: `req_ready_o`=1. On a handshake, latch addr, len and wrap, clear the beat counters, and go to BURST.
  - BURST: issue reads. When the issue counter reaches len+1, go to DRAIN.
  - DRAIN: wait until every issued beat has been handshaken on the response port, then go to IDLE.
- Beat address, for index i from 0 to len:
  - Incrementing burst: `base + 4*i`, truncated to ADDR_WIDTH.
  - Wrapping burst with len+1 ∈ {1,2,4,8,16}: the word-offset bits below log2(len+1) are `(start_word + i) mod (len+1)`, and the upper bits are held. Address carry across the block boundary is suppressed.
  - Wrapping burst with len+1 not a power of two: treated as incrementing.
- Flow control:
  - The output uses a 2-entry skid FIFO.
  - A read is issued only while the count of in-flight reads plus occupied FIFO entries is at most 1. This guarantees read data never overflows the FIFO.
- `resp_data_o` comes from the FIFO head.
- `resp_last_o` is 1 on the beat whose response index equals len.
- There is no abort. A burst always runs to completion, and the initiator discards beats it no longer needs after a flush.
- `bus_busy_o` is 1 in BURST and DRAIN, and 0 in IDLE.

## Timing
- Reset values:
  - Outputs: `req_ready_o`=0 while `rst`=1, then 1 in the cycle after release. `resp_valid_o`=0, `resp_last_o`=0, `mem_en_o`=0, `bus_busy_o`=0. `mem_addr_o` and `resp_data_o` are 0.
  - Internal state: FIFO empty, counters 0, FSM in IDLE.
- Reset asserted mid-burst: everything returns to the reset values in the next cycle. In-flight read data is dropped.
- Latency:
  - Request handshake in cycle 0.
  - First `mem_en_o` in cycle 1.
  - First `resp_valid_o` in cycle 2.
- Throughput: with `resp_ready_i` held at 1, one beat per cycle. A burst of n beats has its last beat in cycle n+1, and the FSM is in IDLE and accepts a new request in cycle n+2.
- Backpressure:
  - `resp_valid_o` and the data stay stable until the handshake.
  - Issue stalls once 2 beats are buffered or in flight.
  - Issue resumes the cycle after a handshake frees an entry.
- A FIFO push and pop in the same cycle leave the occupancy unchanged.
- A request is never accepted in BURST or DRAIN: `req_ready_o`=0 there.
- `bus_busy_o` rises in cycle 1, after the handshake in cycle 0, and falls in the cycle the FSM returns to IDLE.

## Structure
- The shared package (`lsu_types.svh`-style) holds:
  - the burst request/response structs (addr, len, wrap / data, last);
  - the FSM state enum;
  - `WORD_BYTES`=4.
- One sub-module is natural: `skid_fifo2`, a parameterised-width 2-entry FIFO with push, pop, full and empty. The wrap-address arithmetic stays inline as a function.

## Test plan
- Single beat: addr 0x1C000000, len 0, wrap 0, ready held 1. One beat with data = mem[0x1C000000] and `resp_last_o`=1 in cycle 2. `bus_busy_o` is 1 in cycles 1–2 and 0 in cycle 3.
- Wrapping line refill: addr 0x1C000008, len 3, wrap 1. `mem_addr_o` sequence 0x08, 0x0C, 0x00, 0x04 (offsets within the block). Beats arrive in cycles 2–5, last flagged on the 4th.
- Incrementing with carry: addr 0x0000FFF8, len 3, wrap 0. Addresses 0xFFF8, 0xFFFC, 0x10000, 0x10004.
- Backpressure: len 7, `resp_ready_i` toggling 1,0,0,1,… All 8 beats arrive in order with no loss or duplication. `mem_en_o` never leaves more than 2 beats outstanding plus buffered. Data is stable while ready=0.
- Non-power-of-two wrap: len 2, wrap 1, addr 0x...04. Addresses run 0x04, 0x08, 0x0C, as for an incrementing burst.
- Reset mid-burst: assert `rst` at beat 3 of a len-15 burst. Next cycle all outputs are at their reset values. After release, a new len-0 request completes normally with `resp_last_o`=1.
